// File: rtl/mux_nbus_rr.sv
// N-to-1 registered bus mux with fixed-select or round-robin arbitration and valid/ready output.
// Optional transfer counter output CNT is built when MUX_STATS_EN is defined.
module mux_nbus_rr #(
  parameter int unsigned W  = 4,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] D,
  input  logic [N-1:0]   V,
  input  logic [SW-1:0]  S,
  input  logic           MODE,
  input  logic           R,
  output logic [W-1:0]   Q,
  output logic           QV,
  output logic [SW-1:0]  QSEL,
  output logic [N-1:0]   ACK
`ifdef MUX_STATS_EN
  ,
  output logic [15:0]    CNT
`endif
);

  localparam int unsigned NP     = 1 << SW;
  localparam logic [SW:0] NExt   = (SW+1)'(N);
  localparam logic [SW-1:0] LastCh = SW'(N-1);

  logic [W-1:0]  q_q, q_d;
  logic          qv_q, qv_d;
  logic [SW-1:0] qsel_q, qsel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [NP-1:0] v_ext;
  logic          load, cand_ok, capture;
  logic [SW-1:0] cand;
  logic [SW:0]   idx;

  // Zero-extend so any S or scan index can be looked up without going out of range.
  assign v_ext   = NP'(V);
  assign load    = !qv_q || R;
  assign capture = load && cand_ok;

  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    idx     = '0;
    if (!MODE) begin
      if (({1'b0, S} < NExt) && v_ext[S]) begin
        cand_ok = 1'b1;
        cand    = S;
      end
    end else begin
      // Scan PTR, PTR+1, ... wrapping at N; the first valid channel wins.
      for (int unsigned k = 0; k < N; k++) begin
        idx = {1'b0, ptr_q} + (SW+1)'(k);
        if (idx >= NExt) idx = idx - NExt;
        if (!cand_ok && v_ext[idx[SW-1:0]]) begin
          cand_ok = 1'b1;
          cand    = idx[SW-1:0];
        end
      end
    end
  end

  always_comb begin
    q_d    = q_q;
    qv_d   = qv_q;
    qsel_d = qsel_q;
    ptr_d  = ptr_q;
    if (load) begin
      qv_d = cand_ok;
      if (cand_ok) begin
        q_d    = D[32'(cand)*W +: W];
        qsel_d = cand;
        if (MODE) ptr_d = (cand == LastCh) ? '0 : cand + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q    <= '0;
      qv_q   <= 1'b0;
      qsel_q <= '0;
      ptr_q  <= '0;
    end else begin
      q_q    <= q_d;
      qv_q   <= qv_d;
      qsel_q <= qsel_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    ACK = '0;
    if (capture && !RST) ACK = {{(N-1){1'b0}}, 1'b1} << cand;
  end

  assign Q    = q_q;
  assign QV   = qv_q;
  assign QSEL = qsel_q;

`ifdef MUX_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (qv_q && R) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CNT = cnt_q;
`endif

endmodule

// File: doc/mux_nbus_rr.md
Name: mux_nbus_rr

Overview:
Parametrised N-to-1 bus multiplexer with a registered output and a valid/ready output handshake. Successor to the combinational 4-to-1 bus mux.
- Two modes:
  - Fixed mode: the channel is chosen by S.
  - Round-robin mode: fair scan of the valid input channels.
- Sits between several data sources and one downstream consumer.
- Tells each source, with a per-channel ACK, when its data has been taken.

Parameters:
W, 4, data width per channel (bits)
N, 4, number of input channels (2..16)
SW, 2, select/index width; must satisfy 2^SW >= N

Ports:
CLK  input  1  clock, rising edge active
RST  input  1  asynchronous, active-high reset
D  input  N*W  flattened channel data; channel i = D[i*W +: W]
V  input  N  per-channel valid
S  input  SW  channel select, used in fixed mode
MODE  input  1  0 = fixed select, 1 = round-robin
R  input  1  downstream ready
Q  output  W  registered output data
QV  output  1  output valid
QSEL  output  SW  index of the channel held in Q
ACK  output  N  one-hot, combinational; high for the channel captured at the next rising edge

Behaviour:
- One clock (CLK). RST is asynchronous and active-high.
- Reset (asynchronous, immediate): Q=0, QV=0, QSEL=0, internal pointer PTR=0. ACK=0 while RST=1.
- load = !QV || R. The output register may accept new data only when load=1.
- Candidate selection (combinational):
  - MODE=0: candidate = S if S<N and V[S]=1; otherwise no candidate. S>=N always means no candidate.
  - MODE=1: candidate = first channel i with V[i]=1, scanning PTR, PTR+1, …, N-1, 0, …, PTR-1.
- Capture, on a rising edge with load=1 and a candidate present:
  - Q <= D[cand], QSEL <= cand, QV <= 1.
  - ACK[cand]=1 during the preceding cycle; all other ACK bits are 0.
- In MODE=1, each capture sets PTR <= cand+1, wrapping to 0 when cand=N-1. Non-power-of-2 N wraps at N, not at 2^SW.
- On a rising edge with load=1 and no candidate: QV <= 0; Q and QSEL hold their last value.
- On a rising edge with load=0 (QV=1, R=0): Q, QV and QSEL hold. ACK=0. PTR holds.
- Latency: one cycle from a candidate being presented (with load=1) to QV=1.
- Throughput: one word per cycle while R=1.
- Simultaneous events:
  - QV=1, R=1 and a candidate present: the old word is transferred and the new word is captured on the same edge, with no bubble.
- MODE changes take effect on the next combinational evaluation. PTR is retained across mode switches and is not updated while MODE=0.
- Reset asserted mid-transfer: the word is discarded and not re-presented. Sources see ACK=0 while RST=1.
- V and D are sampled only at the capture edge. A source holds D/V stable until it sees ACK.

Optional Feature:
Macro: MUX_STATS_EN
- With the macro defined:
  - Adds output CNT, 16 bits.
  - CNT counts completed downstream transfers (edges with QV=1 and R=1).
  - CNT wraps 16'hFFFF -> 0.
  - CNT resets to 0 on RST.
- Without the macro: the CNT port and its counter logic are absent. All other behaviour is identical.

Test Plan:
1. W=4, N=4, MODE=0, S=2, D2=4'hA, V=4'b0100, R=1 -> ACK=4'b0100 before the edge; after the edge Q=4'hA, QSEL=2, QV=1.
2. Backpressure: hold R=0 with QV=1, Q=4'hA; change D2 to 4'h5 -> Q stays 4'hA and ACK=0 for every R=0 cycle. Raise R=1 -> next edge Q=4'h5.
3. MODE=1, V=4'b1111 held, R=1 from reset -> QSEL sequence 0,1,2,3,0,1 on consecutive cycles, with QV=1 continuously.
4. MODE=1, V=4'b1010, PTR=0 -> QSEL sequence 1,3,1,3. Then set V=0 -> QV=0 after one edge, Q holds its last value.
5. N=3, SW=2:
   - MODE=0, S=3, V=3'b111 -> no capture, QV=0, ACK=0.
   - MODE=1, V=3'b111 -> QSEL 0,1,2,0 (wrap at 3).
6. Assert RST asynchronously mid-cycle while QV=1 -> Q=0, QV=0, QSEL=0 immediately. First capture after release in MODE=1 starts at channel 0. With MUX_STATS_EN defined, CNT=0.
